// File: rtl/core_pipmem_pkg.sv
// Shared types for the KayRV32 memory-access stage: load/store op codes,
// memory FSM states, byte-enable constants and an access-size decode helper.
package core_pipmem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } oper_sel_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic acc_size_e access_size(input oper_sel_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane steering: store byte-enables/replicated write data and
// load byte/half extraction with sign or zero extension; flags misalignment.
module core_lsu_align
  import core_pipmem_pkg::*;
(
  input  oper_sel_e   op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  acc_size_e   size;
  logic [1:0]  eff_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size       = access_size(op);
    misaligned = 1'b0;
    eff_lo     = addr_lo;
    st_be      = BE_WORD;
    st_lane    = st_data;
    // Address bits below the access size are dropped so the access stays aligned.
    case (size)
      SZ_BYTE: begin
        st_be   = BE_BYTE << addr_lo;
        st_lane = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        eff_lo     = {addr_lo[1], 1'b0};
        st_be      = BE_HALF << eff_lo;
        st_lane    = {2{st_data[15:0]}};
      end
      default: begin
        misaligned = |addr_lo;
        eff_lo     = 2'b00;
      end
    endcase

    ld_byte = ld_raw[{eff_lo, 3'b000} +: 8];
    ld_half = ld_raw[{eff_lo[1], 4'b0000} +: 16];
    ld_data = ld_raw;
    case (op)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/core_pipmem.sv
// KayRV32 memory stage: IDLE/REQ/WAIT FSM on a req/gnt/rvalid port, stalls upstream while busy.
// KAYRV32_MISALIGN_TRAP_EN: misaligned half/word accesses are dropped and pulse o_Event.
module core_pipmem
  import core_pipmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  input  logic              i_MemOp,
  input  logic              i_LD_WR,
  input  oper_sel_e         i_Oper_sel,
  input  logic              i_RegWr,
  input  logic [REG_AW-1:0] i_RegFAddr,
  input  logic [ADDR_W-1:0] i_WriteAddr,
  input  logic [DATA_W-1:0] i_WriteData,
  output logic              o_DReq,
  output logic              o_DWe,
  output logic [ADDR_W-1:0] o_DAddr,
  output logic [3:0]        o_DBe,
  output logic [DATA_W-1:0] o_DWData,
  input  logic              i_DGnt,
  input  logic              i_DRValid,
  input  logic [DATA_W-1:0] i_DRData,
  output logic              o_WbEn,
  output logic [REG_AW-1:0] o_WbAddr,
  output logic [DATA_W-1:0] o_WbData,
  output logic              o_StallEn,
  output logic              o_Event
);

`ifdef KAYRV32_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
  logic event_q;
  assign o_Event = event_q;
`else
  localparam logic TRAP_EN = 1'b0;
  assign o_Event = 1'b0;
`endif

  mem_state_e        state;
  oper_sel_e         op_q;
  logic [1:0]        lo_q;
  logic [REG_AW-1:0] rd_q;

  oper_sel_e   sel_op;
  logic [1:0]  sel_lo;
  logic [3:0]  st_be;
  logic [31:0] st_lane;
  logic [31:0] ld_data;
  logic        misaligned;
  logic        trap;

  // The aligner sees the live bundle while idle and the captured one while a load is outstanding.
  assign sel_op    = (state == MEM_IDLE) ? i_Oper_sel : op_q;
  assign sel_lo    = (state == MEM_IDLE) ? i_WriteAddr[1:0] : lo_q;
  assign trap      = TRAP_EN & misaligned;
  assign o_StallEn = (state != MEM_IDLE);

  core_lsu_align u_align (
    .op         (sel_op),
    .addr_lo    (sel_lo),
    .st_data    (i_WriteData),
    .ld_raw     (i_DRData),
    .st_be      (st_be),
    .st_lane    (st_lane),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= MEM_IDLE;
      op_q     <= OP_LB;
      lo_q     <= 2'b00;
      rd_q     <= '0;
      o_DReq   <= 1'b0;
      o_DWe    <= 1'b0;
      o_DAddr  <= '0;
      o_DBe    <= 4'b0000;
      o_DWData <= '0;
      o_WbEn   <= 1'b0;
      o_WbAddr <= '0;
      o_WbData <= '0;
`ifdef KAYRV32_MISALIGN_TRAP_EN
      event_q  <= 1'b0;
`endif
    end else begin
      o_WbEn <= 1'b0;
`ifdef KAYRV32_MISALIGN_TRAP_EN
      event_q <= 1'b0;
`endif
      case (state)
        MEM_IDLE: begin
          if (i_Valid && i_MemOp) begin
            if (trap) begin
`ifdef KAYRV32_MISALIGN_TRAP_EN
              event_q <= 1'b1;
`endif
            end else begin
              state    <= MEM_REQ;
              op_q     <= i_Oper_sel;
              lo_q     <= i_WriteAddr[1:0];
              rd_q     <= i_RegFAddr;
              o_DReq   <= 1'b1;
              o_DWe    <= i_LD_WR;
              o_DAddr  <= {i_WriteAddr[ADDR_W-1:2], 2'b00};
              o_DBe    <= i_LD_WR ? st_be : BE_WORD;
              o_DWData <= i_LD_WR ? st_lane : '0;
            end
          end else if (i_Valid) begin
            o_WbEn   <= i_RegWr && (i_RegFAddr != '0);
            o_WbAddr <= i_RegFAddr;
            o_WbData <= i_WriteData;
          end
        end
        MEM_REQ: begin
          if (i_DGnt) begin
            o_DReq <= 1'b0;
            state  <= o_DWe ? MEM_IDLE : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (i_DRValid) begin
            o_WbEn   <= (rd_q != '0);
            o_WbAddr <= rd_q;
            o_WbData <= ld_data;
            state    <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_pipmem.sv
// Bench for core_pipmem: directed vector table, hand-written reset/stall sequences,
// and randomized traffic checked against a byte-arithmetic reference model.
module tb_core_pipmem;
  import core_pipmem_pkg::*;

  logic        i_Clk;
  logic        i_Rst;
  logic        i_Valid;
  logic        i_MemOp;
  logic        i_LD_WR;
  oper_sel_e   i_Oper_sel;
  logic        i_RegWr;
  logic [4:0]  i_RegFAddr;
  logic [31:0] i_WriteAddr;
  logic [31:0] i_WriteData;
  logic        o_DReq;
  logic        o_DWe;
  logic [31:0] o_DAddr;
  logic [3:0]  o_DBe;
  logic [31:0] o_DWData;
  logic        i_DGnt;
  logic        i_DRValid;
  logic [31:0] i_DRData;
  logic        o_WbEn;
  logic [4:0]  o_WbAddr;
  logic [31:0] o_WbData;
  logic        o_StallEn;
  logic        o_Event;

  int errors = 0;
  int checks = 0;

  core_pipmem dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .i_MemOp(i_MemOp),
    .i_LD_WR(i_LD_WR), .i_Oper_sel(i_Oper_sel), .i_RegWr(i_RegWr),
    .i_RegFAddr(i_RegFAddr), .i_WriteAddr(i_WriteAddr), .i_WriteData(i_WriteData),
    .o_DReq(o_DReq), .o_DWe(o_DWe), .o_DAddr(o_DAddr), .o_DBe(o_DBe),
    .o_DWData(o_DWData), .i_DGnt(i_DGnt), .i_DRValid(i_DRValid), .i_DRData(i_DRData),
    .o_WbEn(o_WbEn), .o_WbAddr(o_WbAddr), .o_WbData(o_WbData),
    .o_StallEn(o_StallEn), .o_Event(o_Event)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input oper_sel_e op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input oper_sel_e op);
    return (op == OP_SB || op == OP_SH || op == OP_SW);
  endfunction

  function automatic logic [31:0] aligned(input oper_sel_e op, input logic [31:0] addr);
    return addr & ~(32'(nbytes(op)) - 32'd1);
  endfunction

  function automatic logic [3:0] ref_be(input oper_sel_e op, input logic [31:0] addr);
    logic [31:0] be;
    if (!is_store(op)) return 4'hF;
    be = ((32'd1 << nbytes(op)) - 32'd1) << (aligned(op, addr) % 4);
    return be[3:0];
  endfunction

  function automatic logic [31:0] ref_wd(input oper_sel_e op, input logic [31:0] d);
    if (nbytes(op) == 1) return 32'(d[7:0]) * 32'h01010101;
    if (nbytes(op) == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input oper_sel_e op, input logic [31:0] addr,
                                           input logic [31:0] raw);
    int n;
    logic [31:0] v, mask;
    n = nbytes(op);
    v = raw >> ((aligned(op, addr) % 4) * 8);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if ((op == OP_LB || op == OP_LH) && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic memop, input logic ld_wr, input oper_sel_e op,
                       input logic regwr, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] data);
    i_Valid = 1'b1; i_MemOp = memop; i_LD_WR = ld_wr; i_Oper_sel = op;
    i_RegWr = regwr; i_RegFAddr = rd; i_WriteAddr = addr; i_WriteData = data;
  endtask

  task automatic run_mem(input oper_sel_e op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [4:0] rd, input int gw, input int rw,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_wb);
    bit st;
    st = is_store(op);
    drive(1'b1, st, op, 1'b0, rd, addr, wdata);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    for (int i = 0; i <= gw; i++) begin
      chk("req_high", 32'(o_DReq), 32'd1);
      chk("stall_req", 32'(o_StallEn), 32'd1);
      chk("dwe", 32'(o_DWe), 32'(st));
      chk("daddr", o_DAddr, e_addr);
      chk("dbe", 32'(o_DBe), 32'(e_be));
      if (st) chk("dwdata", o_DWData, e_wd);
      if (i == gw) i_DGnt = 1'b1;
      @(negedge i_Clk);
      i_DGnt = 1'b0;
    end
    chk("req_drop", 32'(o_DReq), 32'd0);
    if (st) begin
      chk("stall_store_done", 32'(o_StallEn), 32'd0);
    end else begin
      for (int i = 0; i < rw; i++) begin
        chk("stall_wait", 32'(o_StallEn), 32'd1);
        chk("wb_early", 32'(o_WbEn), 32'd0);
        @(negedge i_Clk);
      end
      chk("stall_wait", 32'(o_StallEn), 32'd1);
      i_DRValid = 1'b1;
      i_DRData  = rdata;
      @(negedge i_Clk);
      i_DRValid = 1'b0;
      i_DRData  = $urandom;
      chk("wb_en", 32'(o_WbEn), 32'(rd != 5'd0));
      if (rd != 5'd0) begin
        chk("wb_addr", 32'(o_WbAddr), 32'(rd));
        chk("wb_data", o_WbData, e_wb);
      end
      chk("stall_load_done", 32'(o_StallEn), 32'd0);
      @(negedge i_Clk);
      chk("wb_pulse", 32'(o_WbEn), 32'd0);
    end
  endtask

  task automatic run_trap(input oper_sel_e op, input logic [31:0] addr, input logic [4:0] rd);
    drive(1'b1, is_store(op), op, 1'b0, rd, addr, $urandom);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    chk("trap_event", 32'(o_Event), 32'd1);
    chk("trap_noreq", 32'(o_DReq), 32'd0);
    chk("trap_nostall", 32'(o_StallEn), 32'd0);
    @(negedge i_Clk);
    chk("trap_event_pulse", 32'(o_Event), 32'd0);
    chk("trap_nowb", 32'(o_WbEn), 32'd0);
  endtask

  task automatic passthru(input logic regwr, input logic [4:0] rd, input logic [31:0] data);
    bit en;
    en = regwr && (rd != 5'd0);
    drive(1'b0, 1'b0, OP_LW, regwr, rd, $urandom, data);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    chk("pt_wb_en", 32'(o_WbEn), 32'(en));
    if (en) begin
      chk("pt_wb_addr", 32'(o_WbAddr), 32'(rd));
      chk("pt_wb_data", o_WbData, data);
    end
    chk("pt_noreq", 32'(o_DReq), 32'd0);
    chk("pt_nostall", 32'(o_StallEn), 32'd0);
    @(negedge i_Clk);
    chk("pt_pulse", 32'(o_WbEn), 32'd0);
    if (en) chk("pt_hold", o_WbData, data);
  endtask

  typedef struct {
    oper_sel_e   op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          gw;
    int          rw;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        5'd0, 2, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{OP_SB,  32'h203, 32'h000000A5, 32'h0,        5'd0, 0, 0, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0};
    vecs[2] = '{OP_LB,  32'h301, 32'h0,        32'h00008000, 5'd5, 0, 0, 32'h300, 4'hF, 32'h0, 32'hFFFFFF80};
    vecs[3] = '{OP_LBU, 32'h301, 32'h0,        32'h00008000, 5'd5, 1, 2, 32'h300, 4'hF, 32'h0, 32'h00000080};
    vecs[4] = '{OP_LHU, 32'h302, 32'h0,        32'hBEEF0000, 5'd6, 0, 1, 32'h300, 4'hF, 32'h0, 32'h0000BEEF};
    vecs[5] = '{OP_LW,  32'h400, 32'h0,        32'h12345678, 5'd0, 1, 0, 32'h400, 4'hF, 32'h0, 32'h12345678};
    vecs[6] = '{OP_SH,  32'h106, 32'h0000CAFE, 32'h0,        5'd0, 1, 0, 32'h104, 4'hC, 32'hCAFECAFE, 32'h0};
    vecs[7] = '{OP_LH,  32'h010, 32'h0,        32'h00008001, 5'd3, 0, 0, 32'h010, 4'hF, 32'h0, 32'hFFFF8001};

    i_Rst = 1'b1; i_Valid = 1'b0; i_MemOp = 1'b0; i_LD_WR = 1'b0; i_Oper_sel = OP_LB;
    i_RegWr = 1'b0; i_RegFAddr = 5'd0; i_WriteAddr = 32'd0; i_WriteData = 32'd0;
    i_DGnt = 1'b0; i_DRValid = 1'b0; i_DRData = 32'd0;
    repeat (3) @(negedge i_Clk);

    chk("rst_dreq", 32'(o_DReq), 32'd0);
    chk("rst_dwe", 32'(o_DWe), 32'd0);
    chk("rst_daddr", o_DAddr, 32'd0);
    chk("rst_dbe", 32'(o_DBe), 32'd0);
    chk("rst_dwdata", o_DWData, 32'd0);
    chk("rst_wben", 32'(o_WbEn), 32'd0);
    chk("rst_wbaddr", 32'(o_WbAddr), 32'd0);
    chk("rst_wbdata", o_WbData, 32'd0);
    chk("rst_stall", 32'(o_StallEn), 32'd0);
    chk("rst_event", 32'(o_Event), 32'd0);
    i_Rst = 1'b0;
    @(negedge i_Clk);

    for (int v = 0; v < 8; v++)
      run_mem(vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].rdata, vecs[v].rd,
              vecs[v].gw, vecs[v].rw, vecs[v].e_addr, vecs[v].e_be, vecs[v].e_wd, vecs[v].e_wb);

    passthru(1'b1, 5'd7, 32'h1234);
    passthru(1'b1, 5'd0, 32'h9999);
    passthru(1'b0, 5'd8, 32'h7777);

`ifdef KAYRV32_MISALIGN_TRAP_EN
    run_trap(OP_LW, 32'h102, 5'd4);
    run_trap(OP_SH, 32'h201, 5'd0);
`else
    run_mem(OP_LW, 32'h102, 32'h0, 32'hCAFEF00D, 5'd4, 0, 0, 32'h100, 4'hF, 32'h0, 32'hCAFEF00D);
    run_mem(OP_SH, 32'h201, 32'h00001234, 32'h0, 5'd0, 0, 0, 32'h200, 4'h3, 32'h12341234, 32'h0);
`endif

    // Bundle held during a stall must not be consumed until the FSM is back in IDLE.
    drive(1'b1, 1'b1, OP_SW, 1'b0, 5'd0, 32'h80, 32'h11112222);
    @(negedge i_Clk);
    drive(1'b0, 1'b0, OP_LW, 1'b1, 5'd11, 32'h0, 32'h55);
    chk("hold_stall", 32'(o_StallEn), 32'd1);
    chk("hold_nowb", 32'(o_WbEn), 32'd0);
    i_DGnt = 1'b1;
    @(negedge i_Clk);
    i_DGnt = 1'b0;
    chk("hold_nowb_gnt", 32'(o_WbEn), 32'd0);
    chk("hold_idle", 32'(o_StallEn), 32'd0);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    chk("hold_consumed", 32'(o_WbEn), 32'd1);
    chk("hold_data", o_WbData, 32'h55);
    @(negedge i_Clk);

    // Reset while a load waits for rvalid; the late rvalid must be ignored.
    drive(1'b1, 1'b0, OP_LW, 1'b0, 5'd9, 32'h40, 32'h0);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    i_DGnt = 1'b1;
    @(negedge i_Clk);
    i_DGnt = 1'b0;
    chk("rstw_inwait", 32'(o_StallEn), 32'd1);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    chk("rstw_dreq", 32'(o_DReq), 32'd0);
    chk("rstw_stall", 32'(o_StallEn), 32'd0);
    i_DRValid = 1'b1;
    i_DRData  = 32'hABCD0123;
    @(negedge i_Clk);
    i_DRValid = 1'b0;
    chk("rstw_nowb", 32'(o_WbEn), 32'd0);
    chk("rstw_stall2", 32'(o_StallEn), 32'd0);

    // Reset while a request is pending drops o_DReq.
    drive(1'b1, 1'b1, OP_SW, 1'b0, 5'd0, 32'h44, 32'h1);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    chk("rstr_req", 32'(o_DReq), 32'd1);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    chk("rstr_dreq", 32'(o_DReq), 32'd0);
    chk("rstr_stall", 32'(o_StallEn), 32'd0);
    @(negedge i_Clk);

    for (int it = 0; it < 60; it++) begin
      oper_sel_e   op;
      logic [31:0] addr, wd, rdat;
      logic [4:0]  rd;
      int          gw, rw;
      bit          mis;
      op   = oper_sel_e'(3'($urandom_range(0, 7)));
      addr = $urandom;
      wd   = $urandom;
      rdat = $urandom;
      rd   = 5'($urandom_range(0, 31));
      gw   = $urandom_range(0, 3);
      rw   = $urandom_range(0, 3);
      mis  = (addr % 32'(nbytes(op))) != 0;
      if ($urandom_range(0, 3) == 0) begin
        passthru(1'($urandom_range(0, 1)), rd, wd);
      end else begin
`ifdef KAYRV32_MISALIGN_TRAP_EN
        if (mis) run_trap(op, addr, rd);
        else run_mem(op, addr, wd, rdat, rd, gw, rw, addr & 32'hFFFFFFFC,
                     ref_be(op, addr), ref_wd(op, wd), ref_load(op, addr, rdat));
`else
        if (mis) chk("rand_mis_noevent", 32'(o_Event), 32'd0);
        run_mem(op, addr, wd, rdat, rd, gw, rw, addr & 32'hFFFFFFFC,
                ref_be(op, addr), ref_wd(op, wd), ref_load(op, addr, rdat));
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_pipmem.md
Name: core_pipmem

Overview:
- Memory-access stage of the KayRV32 pipeline; sits between Execute and Writeback.
- Consumes the Execute-stage request bundle: load/store selector, operation, destination register, address, write data.
- Drives the data-memory port with a req/gnt/rvalid handshake and formats load data into a register writeback.
- Requests pipeline stalls while a memory transaction is outstanding; non-memory results pass through with one-cycle latency.

Parameters:
- ADDR_W, 32, data-memory byte-address width
- DATA_W, 32, data width (fixed at 32; other values unsupported)
- REG_AW, 5, register-file address width

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous reset, active-high
- i_Valid  in  1  Execute bundle valid
- i_MemOp  in  1  bundle is a load/store
- i_LD_WR  in  1  0=load, 1=store
- i_Oper_sel  in  OperSel  OP_LB/LH/LW/LBU/LHU/SB/SH/SW
- i_RegWr  in  1  non-memory op writes rd
- i_RegFAddr  in  REG_AW  destination register
- i_WriteAddr  in  ADDR_W  effective byte address
- i_WriteData  in  DATA_W  store data / ALU result
- o_DReq  out  1  memory request
- o_DWe  out  1  1=write
- o_DAddr  out  ADDR_W  word-aligned address ([1:0]=0)
- o_DBe  out  4  byte enables
- o_DWData  out  DATA_W  lane-positioned store data
- i_DGnt  in  1  request accepted
- i_DRValid  in  1  read data valid
- i_DRData  in  DATA_W  read data
- o_WbEn  out  1  writeback strobe
- o_WbAddr  out  REG_AW  writeback register
- o_WbData  out  DATA_W  writeback value
- o_StallEn  out  1  stall upstream stages
- o_Event  out  1  misaligned-access pulse (optional feature)

Behaviour:
- Reset: state IDLE; all outputs 0. Reset mid-transaction drops o_DReq at the next edge; any later i_DRValid is ignored.
- FSM states:
  - IDLE: on i_Valid&i_MemOp, capture the bundle and go to REQ. On i_Valid&!i_MemOp, register the passthrough next edge: o_WbEn=i_RegWr&(i_RegFAddr!=0), o_WbData=i_WriteData.
  - REQ: o_DReq=1 with o_DWe/o_DAddr/o_DBe/o_DWData held stable until i_DGnt. On grant, a store goes to IDLE and a load goes to WAIT.
  - WAIT: o_DReq=0. On i_DRValid, register the formatted data, pulse o_WbEn one cycle (suppressed when rd=0) and go to IDLE.
- Grant and rvalid in the same cycle are not supported; the memory returns rvalid at least one cycle after gnt.
- o_StallEn = (state!=IDLE), decoded from registered state. The bundle presented while stalled is not consumed; upstream holds it. Bundles are consumed only in IDLE.
- Minimum latency:
  - Store: accept N, REQ N+1 (gnt), IDLE N+2.
  - Load: accept N, gnt N+1, rvalid N+2, o_WbEn N+3.
- Store lanes:
  - SB: byte replicated ×4, o_DBe=0001<<a[1:0].
  - SH: halfword replicated ×2, o_DBe=0011<<(2·a[1]).
  - SW: o_DBe=1111.
- Load extract:
  - LB/LBU: byte a[1:0], sign/zero extended.
  - LH/LHU: half a[1], sign/zero extended.
  - LW: whole word.
- Loads drive o_DBe=1111.
- o_WbEn is a single-cycle pulse, 0 otherwise. o_WbAddr/o_WbData hold their last value.

Optional Feature:
- Macro: KAYRV32_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with a[0]=1, or word with a[1:0]!=0: no request, no writeback.
  - o_Event pulses one cycle the edge after capture; state returns to IDLE.
- Undefined:
  - Low address bits below the access size are forced to zero; the access proceeds aligned.
  - o_Event is tied 0.

Decomposition:
- Add to kayrv32_defines.vh:
  - OP_LB..OP_SW codes
  - MEM FSM state encodings (IDLE/REQ/WAIT)
  - byte-enable constants
- One combinational sub-module, core_lsu_align: store lane/byte-enable generation and load extract/extend. The FSM remains in core_pipmem.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> o_DAddr=0x100, o_DBe=1111, o_DWData=0xDEADBEEF held 3 cycles; o_StallEn high for 3 cycles.
- SB addr 0x203, data 0x000000A5 -> o_DAddr=0x200, o_DBe=1000, o_DWData=0xA5A5A5A5.
- LB addr 0x301 rd=x5, i_DRData=0x00008000 -> o_WbData=0xFFFFFF80 on x5. Same with LBU -> 0x00000080. LHU addr 0x302 with i_DRData=0xBEEF0000 -> 0x0000BEEF.
- LW rd=x0 -> transaction completes, o_WbEn stays 0. ADD result 0x1234 rd=x7 -> o_WbEn pulse next cycle, o_WbData=0x1234, no o_DReq.
- Assert i_Rst during WAIT, then i_DRValid -> o_DReq/o_StallEn 0 after the edge, no o_WbEn.
- LW addr 0x102:
  - With the macro: o_Event pulse, no o_DReq.
  - Without: o_DAddr=0x100, load completes normally.
